// File: rtl/fpu_pkg.sv
// Field layout, constants and FSM encoding shared by the
// 37-bit FPU adder-subtractor operand datapath.
package fpu_pkg;

    localparam int SIGN_BIT = 36;
    localparam int EXP_HI   = 35;
    localparam int EXP_LO   = 28;
    localparam int MANT_HI  = 27;
    localparam int MANT_LO  = 0;
    localparam int EXP_W    = EXP_HI - EXP_LO + 1;
    localparam int MANT_W   = MANT_HI - MANT_LO + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [36:0]      QNAN    = {1'b0, 8'hFF, 28'hC000000};

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMP     = 3'd1;
    localparam logic [2:0] ST_ALIGN   = 3'd2;
    localparam logic [2:0] ST_ADD     = 3'd3;
    localparam logic [2:0] ST_NORM    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_SPECIAL = 3'd6;

    function automatic fp_t unpack(input logic [36:0] v);
        fp_t r;
        r.sign = v[SIGN_BIT];
        r.exp  = v[EXP_HI:EXP_LO];
        r.mant = v[MANT_HI:MANT_LO];
        return r;
    endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// Magnitude ordering of two operands: effective exponents,
// swap decision and alignment distance.
module fp_mag_cmp
    import fpu_pkg::*;
(
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [MANT_W-1:0] b_mant,
    output logic              swap,
    output logic [EXP_W-1:0]  e_big,
    output logic [EXP_W-1:0]  d
);

    logic [EXP_W-1:0]        ea;
    logic [EXP_W-1:0]        eb;
    logic [EXP_W+MANT_W:0]   key_a;
    logic [EXP_W+MANT_W:0]   key_b;

    // exp 0 behaves as exp 1 but ranks just below a true exp 1
    always_comb begin
        ea    = (a_exp == '0) ? EXP_W'(1) : a_exp;
        eb    = (b_exp == '0) ? EXP_W'(1) : b_exp;
        key_a = {ea, |a_exp, a_mant};
        key_b = {eb, |b_exp, b_mant};
        swap  = key_b > key_a;
        e_big = swap ? eb : ea;
        d     = swap ? (eb - ea) : (ea - eb);
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Iterative add/subtract sequencer: order, align, add,
// normalise; result handed on with G/R/S left unrounded.
module fp_addsub_seq
    import fpu_pkg::*;
#(
    parameter int W         = 37,
    parameter int EW        = 8,
    parameter int MAX_ALIGN = 29
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic         out_sw,
    output logic         out_zero,
    output logic         out_ovf,
    output logic         out_inv,
    output logic         busy
);

    logic [2:0]       state;
    fp_t              a_r;
    fp_t              b_r;
    logic [EW-1:0]    cnt;
    logic [MANT_W:0]  acc;

    logic             cmp_swap;
    logic [EXP_W-1:0] cmp_ebig;
    logic [EXP_W-1:0] cmp_d;

    logic             a_sp;
    logic             b_sp;
    logic             a_inf;
    logic             b_inf;

    fp_mag_cmp u_cmp (
        .a_exp  (a_r.exp),
        .a_mant (a_r.mant),
        .b_exp  (b_r.exp),
        .b_mant (b_r.mant),
        .swap   (cmp_swap),
        .e_big  (cmp_ebig),
        .d      (cmp_d)
    );

    assign a_sp  = a_r.exp == EXP_MAX;
    assign b_sp  = b_r.exp == EXP_MAX;
    assign a_inf = a_sp && (a_r.mant == '0);
    assign b_inf = b_sp && (b_r.mant == '0);

    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign busy      = state != ST_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            cnt      <= '0;
            acc      <= '0;
            out_res  <= '0;
            out_sw   <= 1'b0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
            out_inv  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= unpack(in_a);
                        b_r <= unpack({in_b[SIGN_BIT] ^ in_op,
                                       in_b[SIGN_BIT-1:0]});
                        out_sw   <= 1'b0;
                        out_zero <= 1'b0;
                        out_ovf  <= 1'b0;
                        out_inv  <= 1'b0;
                        state    <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (a_sp || b_sp) begin
                        state <= ST_SPECIAL;
                    end else begin
                        // a_r carries the larger operand from here on
                        out_sw  <= cmp_swap;
                        a_r     <= cmp_swap ? b_r : a_r;
                        a_r.exp <= cmp_ebig;
                        b_r     <= cmp_swap ? a_r : b_r;
                        cnt     <= cmp_d;
                        state   <= (cmp_d == '0) ? ST_ADD : ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (cnt >= EW'(MAX_ALIGN)) begin
                        b_r.mant <= {{(MANT_W-1){1'b0}}, |b_r.mant};
                        state    <= ST_ADD;
                    end else begin
                        b_r.mant <= {1'b0, b_r.mant[MANT_W-1:2],
                                     |b_r.mant[1:0]};
                        cnt      <= cnt - 1'b1;
                        if (cnt == EW'(1))
                            state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    if (a_r.sign == b_r.sign)
                        acc <= {1'b0, a_r.mant} + {1'b0, b_r.mant};
                    else
                        acc <= {1'b0, a_r.mant} - {1'b0, b_r.mant};
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    if (acc[MANT_W]) begin
                        if (a_r.exp == EXP_MAX - 8'd1) begin
                            out_res <= {a_r.sign, EXP_MAX,
                                        {MANT_W{1'b0}}};
                            out_ovf <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            acc     <= {1'b0, acc[MANT_W:2],
                                        |acc[1:0]};
                            a_r.exp <= a_r.exp + 8'd1;
                        end
                    end else if (acc == '0) begin
                        out_res  <= '0;
                        out_zero <= 1'b1;
                        state    <= ST_DONE;
                    end else if (acc[MANT_W-1]) begin
                        out_res <= {a_r.sign, a_r.exp,
                                    acc[MANT_W-1:0]};
                        state   <= ST_DONE;
                    end else if (a_r.exp > 8'd1) begin
                        acc     <= {acc[MANT_W-1:0], 1'b0};
                        a_r.exp <= a_r.exp - 8'd1;
                    end else begin
                        out_res <= {a_r.sign, {EXP_W{1'b0}},
                                    acc[MANT_W-1:0]};
                        state   <= ST_DONE;
                    end
                end
                ST_SPECIAL: begin
                    if (a_inf && b_inf && (a_r.sign != b_r.sign)) begin
                        out_res <= QNAN;
                        out_inv <= 1'b1;
                    end else if (a_sp) begin
                        out_res <= a_r;
                    end else begin
                        out_res <= b_r;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: arithmetic, specials,
// back-pressure and mid-operation reset.
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] in_a;
    logic [36:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [36:0] out_res;
    logic        out_sw;
    logic        out_zero;
    logic        out_ovf;
    logic        out_inv;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [36:0] res;
        logic [3:0]  flags;
        int          lat;
    } rec_t;

    rec_t sb[$];
    rec_t obs[$];

    localparam logic [36:0] QN = {1'b0, 8'hFF, 28'hC000000};

    fp_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_sw    (out_sw),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_inv   (out_inv),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] mk(input logic s,
                                       input logic [7:0] e,
                                       input logic [27:0] m);
        return {s, e, m};
    endfunction

    task automatic run_op(input logic [36:0] a, input logic [36:0] b,
                          input logic op, output rec_t o);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        o.lat = 0;
        while (!out_valid && o.lat < 200) begin
            @(posedge clk);
            #1;
            o.lat++;
        end
        o.res = out_res;
        o.flags = {out_sw, out_zero, out_ovf, out_inv};
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic issue(input logic [36:0] a, input logic [36:0] b,
                         input logic op, input logic [36:0] er,
                         input logic [3:0] ef, input int el);
        rec_t e;
        rec_t o;
        e.res = er;
        e.flags = ef;
        e.lat = el;
        sb.push_back(e);
        run_op(a, b, op, o);
        obs.push_back(o);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=100",
                     {in_ready, out_valid, busy});
        end
        checks++;
        if ({out_res, out_sw, out_zero, out_ovf, out_inv} !== 41'd0) begin
            failures++;
            $display("FAIL reset_out got=%h/%b exp=0", out_res,
                     {out_sw, out_zero, out_ovf, out_inv});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        rec_t e;
        rec_t o;
        int n = 0;
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b0,
              mk(0,8'h80,28'h8000000), 4'b0000, 4);
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'h80,28'h8000000), 1'b0,
              mk(0,8'h80,28'hC000000), 4'b1000, 4);
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b1,
              37'd0, 4'b0100, 3);
        issue(mk(0,8'h80,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b1,
              mk(0,8'h7F,28'h8000000), 4'b0000, 5);
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'h80,28'h8000000), 1'b1,
              mk(1,8'h7F,28'h8000000), 4'b1000, 5);
        issue(mk(0,8'h9F,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b0,
              mk(0,8'h9F,28'h8000001), 4'b0000, 4);
        issue(mk(0,8'h9C,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b0,
              mk(0,8'h9C,28'h8000001), 4'b0000, 4);
        issue(mk(0,8'h9B,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b0,
              mk(0,8'h9B,28'h8000001), 4'b0000, 31);
        issue(mk(0,8'h00,28'h4000000), mk(0,8'h00,28'h4000000), 1'b0,
              mk(0,8'h01,28'h8000000), 4'b0000, 3);
        issue(mk(0,8'h01,28'h8000000), mk(0,8'h00,28'h4000000), 1'b1,
              mk(0,8'h00,28'h4000000), 4'b0000, 3);
        issue(mk(0,8'h00,28'h4000000), mk(0,8'h01,28'h8000000), 1'b0,
              mk(0,8'h01,28'hC000000), 4'b1000, 3);
        issue(mk(0,8'h90,28'h8000001), mk(0,8'h90,28'h8000000), 1'b1,
              mk(0,8'h75,28'h8000000), 4'b0000, 30);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL arith%0d_res got=%h exp=%h", n, o.res, e.res);
            end
            checks++;
            if (o.flags !== e.flags) begin
                failures++;
                $display("FAIL arith%0d_flags got=%b exp=%b", n, o.flags,
                         e.flags);
            end
            checks++;
            if (o.lat !== e.lat) begin
                failures++;
                $display("FAIL arith%0d_lat got=%0d exp=%0d", n, o.lat,
                         e.lat);
            end
            n++;
        end
    endtask

    task automatic test_special();
        rec_t e;
        rec_t o;
        int n = 0;
        issue(mk(0,8'hFF,28'h0), mk(1,8'hFF,28'h0), 1'b0,
              QN, 4'b0001, 2);
        issue(mk(0,8'hFF,28'h0), mk(0,8'hFF,28'h0), 1'b1,
              QN, 4'b0001, 2);
        issue(mk(0,8'hFF,28'h0), mk(0,8'hFF,28'h0), 1'b0,
              mk(0,8'hFF,28'h0), 4'b0000, 2);
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'hFF,28'h4000000), 1'b1,
              mk(1,8'hFF,28'h4000000), 4'b0000, 2);
        issue(mk(0,8'hFE,28'h8000000), mk(0,8'hFE,28'h8000000), 1'b0,
              mk(0,8'hFF,28'h0), 4'b0010, 3);
        issue(mk(1,8'hFE,28'h8000000), mk(1,8'hFE,28'hC000000), 1'b0,
              mk(1,8'hFF,28'h0), 4'b1010, 3);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o.res !== e.res) begin
                failures++;
                $display("FAIL spec%0d_res got=%h exp=%h", n, o.res, e.res);
            end
            checks++;
            if (o.flags !== e.flags) begin
                failures++;
                $display("FAIL spec%0d_flags got=%b exp=%b", n, o.flags,
                         e.flags);
            end
            checks++;
            if (o.lat !== e.lat) begin
                failures++;
                $display("FAIL spec%0d_lat got=%0d exp=%0d", n, o.lat,
                         e.lat);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t e;
        rec_t o;
        int n = 0;
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b0,
              mk(0,8'h80,28'h8000000), 4'b0000, 4);
        issue(mk(0,8'h80,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b1,
              mk(0,8'h7F,28'h8000000), 4'b0000, 5);
        while (sb.size() > 0 && obs.size() > 0) begin
            e = sb.pop_front();
            o = obs.pop_front();
            checks++;
            if (o.res !== e.res || o.lat !== e.lat) begin
                failures++;
                $display("FAIL b2b%0d got=%h/%0d exp=%h/%0d", n, o.res,
                         o.lat, e.res, e.lat);
            end
            n++;
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] er;
        int w = 0;
        er = mk(0,8'h80,28'hC000000);
        @(negedge clk);
        in_a = mk(0,8'h7F,28'h8000000);
        in_b = mk(0,8'h80,28'h8000000);
        in_op = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (!out_valid && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_timeout got=%b exp=1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                busy !== 1'b1 || out_res !== er || out_sw !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b%b%b/%h exp=101/%h", i,
                         out_valid, in_ready, busy, out_res, er);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release got=%b exp=010",
                     {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_reset_mid();
        rec_t e;
        rec_t o;
        @(negedge clk);
        in_a = mk(0,8'h90,28'h8000001);
        in_b = mk(0,8'h90,28'h8000000);
        in_op = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy got=%b%b exp=10", busy, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_sw, out_zero, out_ovf,
             out_inv} !== 7'b1000000 || out_res !== 37'd0) begin
            failures++;
            $display("FAIL mid_reset got=%b/%h exp=1000000/0",
                     {in_ready, out_valid, busy, out_sw, out_zero,
                      out_ovf, out_inv}, out_res);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(mk(0,8'h7F,28'h8000000), mk(0,8'h7F,28'h8000000), 1'b0,
              mk(0,8'h80,28'h8000000), 4'b0000, 4);
        e = sb.pop_front();
        o = obs.pop_front();
        checks++;
        if (o.res !== e.res || o.flags !== e.flags || o.lat !== e.lat) begin
            failures++;
            $display("FAIL mid_after got=%h/%b/%0d exp=%h/%b/%0d", o.res,
                     o.flags, o.lat, e.res, e.flags, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
